wt_store_split: RTL and testbench

WT_STORE_SPLIT -- requirements
Module: wt_store_split

---
 rtl/wt_store_split.sv | 80 ++++++++
 tb/tb_wt_store_split.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wt_store_split.sv
// wt_store_split: splits a dword store with arbitrary byte enables into L1.5-legal chunks
module wt_store_split #(
  parameter int PADDR_W = 56,
  parameter int ID_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [PADDR_W-1:0] req_paddr_i,
  input  logic [63:0]        req_data_i,
  input  logic [7:0]         req_be_i,
  input  logic [ID_W-1:0]    req_id_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PADDR_W-1:0] out_paddr_o,
  output logic [63:0]        out_data_o,
  output logic [1:0]         out_size_o,
  output logic [7:0]         out_be_o,
  output logic [ID_W-1:0]    out_id_o,
  output logic               out_last_o,
  output logic               busy_o
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t             r_state;
  logic [PADDR_W-1:0] r_base;
  logic [63:0]        r_data;
  logic [7:0]         r_rem;
  logic [ID_W-1:0]    r_id;
  logic               r_aln;
  logic [2:0]         w_off;
  logic [7:0]         w_mask;
  logic [7:0]         w_byte;
  logic [15:0]        w_hw;
  logic [31:0]        w_wd;
  logic               w_ohs, w_acc, w_aln_in;
  always_comb begin
    w_off = '0;
    for (int i = 7; i >= 0; i--) w_off = r_rem[i] ? 3'(i) : w_off;
  end
  // an aligned pattern goes out whole; anything else peels off its lowest byte
  assign w_mask = r_aln ? r_rem : (r_rem & (~r_rem + 8'd1));
  assign w_byte = r_data[{w_off, 3'b000} +: 8];
  assign w_hw = r_data[{w_off[2:1], 4'b0000} +: 16];
  assign w_wd = r_data[{w_off[2], 5'b00000} +: 32];
  assign w_aln_in = req_be_i inside {8'hFF, 8'h0F, 8'hF0, 8'h03, 8'h0C, 8'h30, 8'hC0};
  assign out_valid_o = r_state == SEND;
  assign busy_o = out_valid_o;
  assign out_last_o = out_valid_o && (r_rem == w_mask);
  assign out_be_o = w_mask;
  assign out_id_o = r_id;
  assign out_paddr_o = r_base | PADDR_W'(w_off);
  assign out_size_o = !r_aln ? 2'd0 : r_rem == 8'hFF ? 2'd3 :
                      (r_rem == 8'h0F || r_rem == 8'hF0) ? 2'd2 : 2'd1;
  assign out_data_o = out_size_o == 2'd3 ? r_data : out_size_o == 2'd2 ? {2{w_wd}} :
                      out_size_o == 2'd1 ? {4{w_hw}} : {8{w_byte}};
  assign w_ohs = out_valid_o & out_ready_i;
  assign req_ready_o = (r_state == IDLE) | (w_ohs & out_last_o);
  assign w_acc = req_valid_i & req_ready_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_data  <= '0;
      r_rem   <= '0;
      r_id    <= '0;
      r_aln   <= 1'b0;
    end else if (w_acc) begin
      r_state <= (req_be_i != 8'h00) ? SEND : IDLE;
      r_base  <= req_paddr_i & ~PADDR_W'(7);
      r_data  <= req_data_i;
      r_rem   <= req_be_i;
      r_id    <= req_id_i;
      r_aln   <= w_aln_in;
    end else if (w_ohs) begin
      r_rem <= r_rem & ~w_mask;
      if (out_last_o) r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_wt_store_split.sv
// tb_wt_store_split: directed vector table plus multi-cycle sequences for wt_store_split
module tb_wt_store_split;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [55:0] req_paddr;
  logic [63:0] req_data;
  logic [7:0]  req_be;
  logic [3:0]  req_id;
  logic        out_valid, out_ready;
  logic [55:0] out_paddr;
  logic [63:0] out_data;
  logic [1:0]  out_size;
  logic [7:0]  out_be;
  logic [3:0]  out_id;
  logic        out_last, busy;
  int n_chk = 0;
  int n_fail = 0;

  wt_store_split #(.PADDR_W(56), .ID_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_paddr_i(req_paddr), .req_data_i(req_data), .req_be_i(req_be), .req_id_i(req_id),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_paddr_o(out_paddr), .out_data_o(out_data), .out_size_o(out_size),
    .out_be_o(out_be), .out_id_o(out_id), .out_last_o(out_last), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [3:0]  id;
    logic [1:0]  size;
    logic [55:0] opaddr;
    logic [63:0] odata;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [55:0] pa, input logic [63:0] d, input logic [7:0] be, input logic [3:0] id);
    req_valid = 1'b1;
    req_paddr = pa;
    req_data = d;
    req_be = be;
    req_id = id;
    #1;
  endtask

  initial begin
    logic [7:0]  s_be[3];
    logic [55:0] s_pa[3];
    logic [63:0] s_d[3];
    tv[0] = '{56'h1000, 64'h1122334455667788, 8'hFF, 4'h1, 2'd3, 56'h1000, 64'h1122334455667788};
    tv[1] = '{56'h1003, 64'h0000ABCD00000000, 8'h30, 4'h2, 2'd1, 56'h1004, 64'hABCDABCDABCDABCD};
    tv[2] = '{56'h2005, 64'hDEADBEEF01234567, 8'hF0, 4'h3, 2'd2, 56'h2004, 64'hDEADBEEFDEADBEEF};
    tv[3] = '{56'h2007, 64'hDEADBEEF01234567, 8'h0F, 4'h4, 2'd2, 56'h2000, 64'h0123456701234567};
    tv[4] = '{56'h3000, 64'h9A11223344556677, 8'h80, 4'h5, 2'd0, 56'h3007, 64'h9A9A9A9A9A9A9A9A};
    tv[5] = '{56'h3008, 64'h1122334455667788, 8'h03, 4'h6, 2'd1, 56'h3008, 64'h7788778877887788};
    tv[6] = '{56'h3010, 64'h1122334455667788, 8'hC0, 4'h7, 2'd1, 56'h3016, 64'h1122112211221122};
    tv[7] = '{56'h3019, 64'h1122334455667788, 8'h01, 4'h8, 2'd0, 56'h3018, 64'h8888888888888888};
    rst = 1'b1;
    req_valid = 1'b0;
    req_paddr = '0;
    req_data = '0;
    req_be = '0;
    req_id = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_be", 64'(out_be), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_paddr", 64'(out_paddr), 64'd0);
    rst = 1'b0;
    step();
    chk("rst_ready", 64'(req_ready), 64'd1);

    for (int k = 0; k < 8; k++) begin
      drive(tv[k].paddr, tv[k].data, tv[k].be, tv[k].id);
      chk($sformatf("v%0d_ready", k), 64'(req_ready), 64'd1);
      chk($sformatf("v%0d_nocomb", k), 64'(out_valid), 64'd0);
      step();
      req_valid = 1'b0;
      chk($sformatf("v%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_size", k), 64'(out_size), 64'(tv[k].size));
      chk($sformatf("v%0d_paddr", k), 64'(out_paddr), 64'(tv[k].opaddr));
      chk($sformatf("v%0d_data", k), out_data, tv[k].odata);
      chk($sformatf("v%0d_be", k), 64'(out_be), 64'(tv[k].be));
      chk($sformatf("v%0d_id", k), 64'(out_id), 64'(tv[k].id));
      chk($sformatf("v%0d_last", k), 64'(out_last), 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("v%0d_done", k), 64'(out_valid), 64'd0);
    end

    s_be = '{8'h02, 8'h04, 8'h10};
    s_pa = '{56'h3801, 56'h3802, 56'h3804};
    s_d = '{64'h7777777777777777, 64'h6666666666666666, 64'h4444444444444444};
    drive(56'h3800, 64'h1122334455667788, 8'h16, 4'h9);
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("b16_%0d_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("b16_%0d_size", c), 64'(out_size), 64'd0);
      chk($sformatf("b16_%0d_be", c), 64'(out_be), 64'(s_be[c]));
      chk($sformatf("b16_%0d_paddr", c), 64'(out_paddr), 64'(s_pa[c]));
      chk($sformatf("b16_%0d_data", c), out_data, s_d[c]);
      chk($sformatf("b16_%0d_id", c), 64'(out_id), 64'h9);
      chk($sformatf("b16_%0d_last", c), 64'(out_last), 64'(c == 2));
      out_ready = 1'b1;
      #1;
      chk($sformatf("b16_%0d_ready", c), 64'(req_ready), 64'(c == 2));
      step();
      out_ready = 1'b0;
    end
    chk("b16_done", 64'(out_valid), 64'd0);

    drive(56'h4000, 64'hCAFEF00D12345678, 8'h0F, 4'hA);
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_data", c), out_data, 64'h1234567812345678);
      chk($sformatf("stall%0d_be", c), 64'(out_be), 64'h0F);
      chk($sformatf("stall%0d_paddr", c), 64'(out_paddr), 64'h4000);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("stall_done", 64'(out_valid), 64'd0);
    step();
    out_ready = 1'b0;
    chk("stall_nodup", 64'(out_valid), 64'd0);

    drive(56'h5000, 64'h1122334455667788, 8'h03, 4'h1);
    step();
    chk("b2b_1_size", 64'(out_size), 64'd1);
    chk("b2b_1_data", out_data, 64'h7788778877887788);
    drive(56'h6000, 64'hA5A5A5A55A5A5A5A, 8'hFF, 4'h2);
    out_ready = 1'b1;
    #1;
    chk("b2b_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    chk("b2b_2_valid", 64'(out_valid), 64'd1);
    chk("b2b_2_size", 64'(out_size), 64'd3);
    chk("b2b_2_paddr", 64'(out_paddr), 64'h6000);
    chk("b2b_2_data", out_data, 64'hA5A5A5A55A5A5A5A);
    chk("b2b_2_id", 64'(out_id), 64'h2);
    step();
    out_ready = 1'b0;
    chk("b2b_done", 64'(out_valid), 64'd0);

    drive(56'h7000, 64'h1122334455667788, 8'h81, 4'h3);
    step();
    req_valid = 1'b0;
    chk("r81_0_be", 64'(out_be), 64'h01);
    chk("r81_0_data", out_data, 64'h8888888888888888);
    chk("r81_0_last", 64'(out_last), 64'd0);
    out_ready = 1'b1;
    step();
    chk("r81_1_be", 64'(out_be), 64'h80);
    chk("r81_1_paddr", 64'(out_paddr), 64'h7007);
    chk("r81_1_last", 64'(out_last), 64'd1);
    rst = 1'b1;
    drive(56'h7100, 64'hFFFF0000FFFF0000, 8'hFF, 4'h4);
    step();
    rst = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    chk("r81_valid", 64'(out_valid), 64'd0);
    chk("r81_busy", 64'(busy), 64'd0);
    chk("r81_last", 64'(out_last), 64'd0);
    chk("r81_be", 64'(out_be), 64'd0);
    chk("r81_data", out_data, 64'd0);
    step();
    chk("r81_idle", 64'(out_valid), 64'd0);
    chk("r81_ready", 64'(req_ready), 64'd1);

    drive(56'h8000, 64'h0123456789ABCDEF, 8'h00, 4'h5);
    chk("be0_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    chk("be0_valid", 64'(out_valid), 64'd0);
    chk("be0_busy", 64'(busy), 64'd0);
    step();
    chk("be0_valid2", 64'(out_valid), 64'd0);
    chk("be0_ready2", 64'(req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
